// File: rtl/fx_param_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : fx_param_controller_if
//  Description : Front-panel bus of the effects parameter controller.
//                Carries the raw push-buttons and selector switches in, and
//                the per-effect parameter values out to the effect datapaths.
//  Modports    : master - board/effects side (drives keys and switches)
//                slave  - the controller (drives parameter outputs)
//  Signals     : KEY3/KEY2 (active-low buttons), SW[9:0], active_fx[1:0],
//                trem_divisor[12:0], trem_frequency[31:0], trem_busy,
//                echo_delay[15:0], dist_gain[3:0], param_update
//  Revision    : 1.0 - initial release
// ============================================================================
interface fx_param_controller_if;
    logic        KEY3;
    logic        KEY2;
    logic [9:0]  SW;
    logic [1:0]  active_fx;
    logic [12:0] trem_divisor;
    logic [31:0] trem_frequency;
    logic        trem_busy;
    logic [15:0] echo_delay;
    logic [3:0]  dist_gain;
    logic        param_update;

    modport master (
        output KEY3, KEY2, SW,
        input  active_fx, trem_divisor, trem_frequency, trem_busy,
               echo_delay, dist_gain, param_update
    );

    modport slave (
        input  KEY3, KEY2, SW,
        output active_fx, trem_divisor, trem_frequency, trem_busy,
               echo_delay, dist_gain, param_update
    );
endinterface
`default_nettype wire

// File: rtl/fx_param_controller.sv
`default_nettype none
// ============================================================================
//  Module      : fx_param_controller
//  Description : Shares the up (KEY3) / down (KEY2) buttons between the
//                tremolo, echo and distortion effects, holds each effect's
//                parameter and derives the tremolo LFO frequency with a
//                32-step sequential restoring divider.
//  Ports       : CLK    - system clock
//                RST_N  - asynchronous active-low reset
//                bus    - fx_param_controller_if.slave (keys, switches,
//                         parameter outputs, busy and update strobe)
//  Revision    : 1.0 - initial release
// ============================================================================
module fx_param_controller #(
    parameter int unsigned CLK_HZ          = 50000000,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned TREM_INIT       = 2560,
    parameter int unsigned TREM_STEP       = 256,
    parameter int unsigned TREM_MIN        = 256,
    parameter int unsigned TREM_MAX        = 5120,
    parameter int unsigned ECHO_INIT       = 8192,
    parameter int unsigned ECHO_STEP       = 1024,
    parameter int unsigned ECHO_MAX        = 32768,
    parameter int unsigned GAIN_INIT       = 4,
    parameter int unsigned GAIN_MAX        = 15
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    fx_param_controller_if.slave bus
);

    localparam int CNTW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNTW-1:0] C_CNT_LAST  = CNTW'(DEBOUNCE_CYCLES - 1);
    localparam logic [12:0]     C_TREM_INIT = 13'(TREM_INIT);
    localparam logic [12:0]     C_TREM_STEP = 13'(TREM_STEP);
    localparam logic [12:0]     C_TREM_MIN  = 13'(TREM_MIN);
    localparam logic [12:0]     C_TREM_MAX  = 13'(TREM_MAX);
    localparam logic [15:0]     C_ECHO_INIT = 16'(ECHO_INIT);
    localparam logic [15:0]     C_ECHO_STEP = 16'(ECHO_STEP);
    localparam logic [15:0]     C_ECHO_MAX  = 16'(ECHO_MAX);
    localparam logic [3:0]      C_GAIN_INIT = 4'(GAIN_INIT);
    localparam logic [3:0]      C_GAIN_MAX  = 4'(GAIN_MAX);
    localparam logic [31:0]     C_DIVIDEND  = 32'(CLK_HZ);
    // Frequency for the reset divisor is fixed at elaboration, so reset
    // never has to run the divider.
    localparam logic [31:0]     C_FREQ_INIT = 32'(CLK_HZ / TREM_INIT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Key path: 2-FF synchronizer, debounce counter, press pulse.
    // Index 1 = KEY3 (up), index 0 = KEY2 (down).
    // ------------------------------------------------------------------
    logic [1:0] w_key_raw;
    logic [1:0] w_press;

    assign w_key_raw = {bus.KEY3, bus.KEY2};

    generate
        for (genvar k = 0; k < 2; k++) begin : g_key
            logic            meta_q;
            logic            sync_q;
            logic            deb_q;
            logic            press_q;
            logic [CNTW-1:0] cnt_q;

            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    meta_q  <= 1'b1;
                    sync_q  <= 1'b1;
                    deb_q   <= 1'b1;
                    press_q <= 1'b0;
                    cnt_q   <= '0;
                end else begin
                    meta_q <= w_key_raw[k];
                    sync_q <= meta_q;
                    if (sync_q != deb_q) begin
                        // Accept the new level on its Nth consecutive cycle.
                        if (cnt_q == C_CNT_LAST) begin
                            deb_q   <= sync_q;
                            cnt_q   <= '0;
                            press_q <= ~sync_q;
                        end else begin
                            cnt_q   <= cnt_q + 1'b1;
                            press_q <= 1'b0;
                        end
                    end else begin
                        cnt_q   <= '0;
                        press_q <= 1'b0;
                    end
                end
            end

            assign w_press[k] = press_q;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Parameter registers and tremolo divider FSM
    // ------------------------------------------------------------------
    state_t      state_q;
    logic [1:0]  active_q, active_d;
    logic [12:0] div_q, div_d;
    logic [31:0] freq_q;
    logic [15:0] echo_q, echo_d;
    logic [3:0]  gain_q, gain_d;
    logic        busy_q;
    logic        pu_q;
    logic [12:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [4:0]  iter_q;

    logic        w_up, w_dn;
    logic        w_trem_dec, w_trem_inc, w_trem_start;
    logic        w_echo_up, w_echo_dn, w_gain_up, w_gain_dn;
    logic        w_div_last;
    logic [13:0] w_rem_sh;
    logic        w_ge;
    logic        w_unused_sw;

    assign w_unused_sw = ^bus.SW[6:0];

    // Simultaneous up and down events cancel each other.
    assign w_up = w_press[1] & ~w_press[0];
    assign w_dn = w_press[0] & ~w_press[1];

    always_comb begin
        active_d = 2'd0;
        if (bus.SW[9])      active_d = 2'd1;
        else if (bus.SW[8]) active_d = 2'd2;
        else if (bus.SW[7]) active_d = 2'd3;
    end

    // Up lowers the tremolo divisor (faster LFO); tremolo events are
    // ignored while a division is in flight.
    assign w_trem_dec   = w_up & (active_q == 2'd1) & (state_q != S_DIV) & (div_q > C_TREM_MIN);
    assign w_trem_inc   = w_dn & (active_q == 2'd1) & (state_q != S_DIV) & (div_q < C_TREM_MAX);
    assign w_trem_start = w_trem_dec | w_trem_inc;
    assign div_d        = w_trem_dec ? (div_q - C_TREM_STEP) :
                          w_trem_inc ? (div_q + C_TREM_STEP) : div_q;

    assign w_echo_up = w_up & (active_q == 2'd2) & (echo_q < C_ECHO_MAX);
    assign w_echo_dn = w_dn & (active_q == 2'd2) & (echo_q > C_ECHO_STEP);
    assign echo_d    = w_echo_up ? (echo_q + C_ECHO_STEP) :
                       w_echo_dn ? (echo_q - C_ECHO_STEP) : echo_q;

    assign w_gain_up = w_up & (active_q == 2'd3) & (gain_q < C_GAIN_MAX);
    assign w_gain_dn = w_dn & (active_q == 2'd3) & (gain_q > 4'd1);
    assign gain_d    = w_gain_up ? (gain_q + 4'd1) :
                       w_gain_dn ? (gain_q - 4'd1) : gain_q;

    // One restoring-division step: shift the next dividend bit into the
    // partial remainder and subtract the divisor when it fits.
    assign w_rem_sh   = {rem_q, quo_q[31]};
    assign w_ge       = (w_rem_sh >= {1'b0, div_q});
    assign rem_d      = w_ge ? 13'(w_rem_sh - {1'b0, div_q}) : w_rem_sh[12:0];
    assign quo_d      = {quo_q[30:0], w_ge};
    assign w_div_last = (state_q == S_DIV) && (iter_q == 5'd31);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= S_IDLE;
            active_q <= 2'd0;
            div_q    <= C_TREM_INIT;
            freq_q   <= C_FREQ_INIT;
            echo_q   <= C_ECHO_INIT;
            gain_q   <= C_GAIN_INIT;
            busy_q   <= 1'b0;
            pu_q     <= 1'b0;
            rem_q    <= '0;
            quo_q    <= '0;
            iter_q   <= '0;
        end else begin
            active_q <= active_d;
            echo_q   <= echo_d;
            gain_q   <= gain_d;
            // A division finishing together with an echo/gain change still
            // yields a single strobe.
            pu_q     <= w_echo_up | w_echo_dn | w_gain_up | w_gain_dn | w_div_last;

            case (state_q)
                S_IDLE, S_DONE: begin
                    if (w_trem_start) begin
                        div_q   <= div_d;
                        busy_q  <= 1'b1;
                        rem_q   <= '0;
                        quo_q   <= C_DIVIDEND;
                        iter_q  <= '0;
                        state_q <= S_DIV;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_DIV: begin
                    rem_q  <= rem_d;
                    quo_q  <= quo_d;
                    iter_q <= iter_q + 5'd1;
                    if (iter_q == 5'd31) begin
                        freq_q  <= quo_d;
                        busy_q  <= 1'b0;
                        state_q <= S_DONE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.active_fx      = active_q;
    assign bus.trem_divisor   = div_q;
    assign bus.trem_frequency = freq_q;
    assign bus.trem_busy      = busy_q;
    assign bus.echo_delay     = echo_q;
    assign bus.dist_gain      = gain_q;
    assign bus.param_update   = pu_q;

endmodule
`default_nettype wire

// File: doc/fx_param_controller.md
Name: fx_param_controller

Overview:
Front-panel parameter controller for the audio effects chain.
- Shares the two push-buttons (KEY3 = up, KEY2 = down) between three effects: tremolo, echo and distortion, chosen by switches.
- Holds each effect's parameter register.
- Computes the tremolo LFO frequency with a sequential restoring divider, so no combinational divider is needed.
- Sits between the board I/O and the effect datapaths, which consume its outputs directly.

Parameters:
CLK_HZ, 50000000, system clock rate; dividend for the tremolo frequency
DEBOUNCE_CYCLES, 500000, cycles a synchronized key must be stable before acceptance
TREM_INIT, 2560, tremolo divisor at reset
TREM_STEP, 256, tremolo divisor step per press
TREM_MIN, 256, lowest tremolo divisor
TREM_MAX, 5120, highest tremolo divisor
ECHO_INIT, 8192, echo delay at reset, in samples
ECHO_STEP, 1024, echo delay step
ECHO_MAX, 32768, highest echo delay; the lowest is ECHO_STEP
GAIN_INIT, 4, distortion gain at reset
GAIN_MAX, 15, highest distortion gain; the lowest is 1

Ports:
CLK  in  1  system clock
RST_N  in  1  asynchronous active-low reset
KEY3  in  1  up button, active-low, asynchronous to CLK
KEY2  in  1  down button, active-low, asynchronous to CLK
SW  in  10  SW[9] selects tremolo, SW[8] echo, SW[7] distortion; other bits unused
active_fx  out  2  0 = none, 1 = tremolo, 2 = echo, 3 = distortion
trem_divisor  out  13  current tremolo divisor
trem_frequency  out  32  CLK_HZ / trem_divisor, truncated
trem_busy  out  1  high while a division is running
echo_delay  out  16  echo delay in samples
dist_gain  out  4  distortion gain
param_update  out  1  one-cycle pulse when any parameter output changes

Behaviour:
- Reset (RST_N=0, asynchronous) drives these values immediately:
  - trem_divisor = TREM_INIT; trem_frequency = 19531 (a precomputed constant; no division at reset).
  - echo_delay = ECHO_INIT; dist_gain = GAIN_INIT.
  - trem_busy = 0; param_update = 0; active_fx = 0.
  - Debouncers are cleared to the released state (1); the FSM goes to IDLE.
- Reset asserted mid-division aborts the division and returns all outputs to the reset values.
- Key input path:
  - Each key passes through a 2-FF synchronizer, then a debounce counter.
  - The debounced level changes only after DEBOUNCE_CYCLES consecutive cycles of a constant synchronized value.
  - A press event is a 1-cycle pulse on the debounced 1→0 transition. Release generates nothing. Holding a key gives one event only.
- Selection:
  - Priority SW[9] > SW[8] > SW[7]; active_fx is registered from SW each cycle.
  - If active_fx = 0, events are dropped.
  - If KEY3 and KEY2 events occur in the same cycle, both are dropped.
- Up event (KEY3):
  - Tremolo: divisor -= TREM_STEP, only if divisor > TREM_MIN.
  - Echo: delay += ECHO_STEP, only if delay < ECHO_MAX.
  - Distortion: gain += 1, only if gain < GAIN_MAX.
- Down event (KEY2):
  - Tremolo: divisor += TREM_STEP, only if divisor < TREM_MAX.
  - Echo: delay -= ECHO_STEP, only if delay > ECHO_STEP.
  - Distortion: gain -= 1, only if gain > 1.
- At a limit the register is unchanged and no pulse is produced. Values saturate; they never wrap.
- Echo and distortion timing: for an event in cycle E, the register updates and param_update = 1 in cycle E+1.
- Tremolo FSM (IDLE → DIV → DONE → IDLE):
  - Event in cycle E: trem_divisor takes its new value and trem_busy = 1 in cycle E+1. This enters DIV.
  - DIV runs 32 restoring-division iterations, one per cycle, cycles E+1..E+32.
  - DONE, cycle E+33: trem_frequency loads the quotient, param_update = 1, trem_busy = 0. Then return to IDLE.
  - trem_frequency holds its old value throughout DIV.
- Tremolo events while trem_busy = 1 are dropped. Events for the other effects are still accepted during a division.
- If an echo/distortion update and DONE fall in the same cycle, a single param_update pulse covers both.
- Changing SW during DIV does not abort the division.
- Division checks: 32-bit dividend; the divisor is never 0, because the limits guarantee it ≥ TREM_MIN. Required quotients are 50000000/256 = 195312 and 50000000/5120 = 9765.

Test Plan:
- Reset, then idle for 100 cycles → trem_divisor = 2560, trem_frequency = 19531, echo_delay = 8192, dist_gain = 4, param_update never high.
- SW[9]=1; KEY3 pressed and held past debounce (DEBOUNCE_CYCLES reduced to 8 in the bench) → divisor 2304 one cycle after the event. busy high for 32 cycles, then frequency 21701 with one param_update pulse. Holding the key longer gives no second event.
- SW[9]=1; 9 KEY3 presses → divisor reaches 256 and frequency 195312. A 10th press → no change and no pulse. Then from reset, 10 KEY2 presses → divisor 5120 and frequency 9765; an 11th press is ignored.
- SW=10'b1110000000 → tremolo has priority. SW[8] only: 24 KEY3 presses → echo_delay saturates at 32768. SW[7] only: 5 KEY2 presses → dist_gain reaches 1 and stays there.
- KEY3 and KEY2 released-to-pressed in the same cycle → no register change. A glitch on KEY3 shorter than DEBOUNCE_CYCLES → no event.
- Start a tremolo division, then drop RST_N at iteration 10 → all outputs return to reset values immediately. After release, a fresh press completes normally.
